// File: rtl/free_list_if.sv
// Rename/retire/checkpoint signal bundle for the physical-register free list.
// The master modport drives requests; the slave modport (the free list) answers them.
interface free_list_if #(
   parameter int unsigned PREG_W = 7,
   parameter int unsigned TAG_W  = 5
);
   logic              alloc_req;
   logic              alloc_grant;
   logic [PREG_W-1:0] alloc_preg;
   logic              empty;
   logic              free_en;
   logic [PREG_W-1:0] free_preg;
   logic              ckpt_en;
   logic [TAG_W-1:0]  ckpt_tag;
   logic              recover;
   logic [TAG_W-1:0]  recover_tag;
   logic [PREG_W:0]   free_count;
   logic              err;

   modport master (
      output alloc_req, free_en, free_preg, ckpt_en, ckpt_tag, recover, recover_tag,
      input  alloc_grant, alloc_preg, empty, free_count, err
   );

   modport slave (
      input  alloc_req, free_en, free_preg, ckpt_en, ckpt_tag, recover, recover_tag,
      output alloc_grant, alloc_preg, empty, free_count, err
   );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical registers with per-branch head checkpoints
// and single-cycle head restore on mispredict.
module free_list #(
   parameter int unsigned NUM_PREGS = 128,
   parameter int unsigned NUM_ARCH  = 32,
   parameter int unsigned NUM_TAGS  = 32,
   parameter int unsigned PREG_W    = 7,
   parameter int unsigned TAG_W     = 5
) (
   input  logic        clk,
   input  logic        reset,
   free_list_if.slave  fl
);
   localparam int unsigned PTR_W     = PREG_W + 1;
   localparam int unsigned INIT_FREE = NUM_PREGS - NUM_ARCH;

   logic [PREG_W-1:0]   r_entry [NUM_PREGS];
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [PTR_W-1:0]    r_ckpt_head [NUM_TAGS];
   logic [NUM_TAGS-1:0] r_ckpt_valid;
   logic                r_err;

   logic [PTR_W-1:0]    w_count;
   logic                w_empty;
   logic                w_full;
   logic                w_grant;
   logic                w_release;
   logic                w_push;
   logic                w_ckpt_hit;
   logic [PTR_W-1:0]    w_head_next;

   // Recover overrides allocation; an unknown tag leaves head where it is.
   always_comb begin
      w_count     = r_tail - r_head;
      w_empty     = (w_count == '0);
      w_full      = (w_count == PTR_W'(NUM_PREGS));
      w_grant     = fl.alloc_req && !w_empty && !fl.recover;
      w_release   = fl.free_en && (fl.free_preg != '0);
      w_push      = w_release && !w_full;
      w_ckpt_hit  = r_ckpt_valid[fl.recover_tag];
      w_head_next = r_head;
      if (fl.recover) begin
         if (w_ckpt_hit) w_head_next = r_ckpt_head[fl.recover_tag];
      end else if (w_grant) begin
         w_head_next = r_head + PTR_W'(1);
      end
   end

   assign fl.alloc_grant = w_grant;
   assign fl.alloc_preg  = r_entry[r_head[PREG_W-1:0]];
   assign fl.empty       = w_empty;
   assign fl.free_count  = w_count;
   assign fl.err         = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head       <= '0;
         r_tail       <= PTR_W'(INIT_FREE);
         r_ckpt_valid <= '0;
         r_err        <= 1'b0;
      end else begin
         r_head <= w_head_next;
         if (w_push) r_tail <= r_tail + PTR_W'(1);
         if ((w_release && w_full) || (fl.recover && !w_ckpt_hit)) r_err <= 1'b1;
         if (fl.recover) begin
            if (w_ckpt_hit) r_ckpt_valid <= '0;
         end else if (fl.ckpt_en) begin
            r_ckpt_valid[fl.ckpt_tag] <= 1'b1;
         end
      end
   end

   // Snapshot includes the same-cycle allocation; slots are qualified by r_ckpt_valid.
   always_ff @(posedge clk) begin
      if (!reset && !fl.recover && fl.ckpt_en) r_ckpt_head[fl.ckpt_tag] <= w_head_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PREGS; i++)
            r_entry[i] <= (i < INIT_FREE) ? PREG_W'(NUM_ARCH + i) : '0;
      end else if (w_push) begin
         r_entry[r_tail[PREG_W-1:0]] <= fl.free_preg;
      end
   end
endmodule
